// File: rtl/comparator_pipe_if.sv
// Operand/result handshake bundle for comparator_pipe.
// The slave side is the comparator; the master side is the producer/consumer pair.
interface comparator_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b
    );

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b
    );
endinterface

// File: rtl/comparator_pipe.sv
// MSB-first chunked magnitude comparator, STAGES registers deep, whole pipe stalls on out_valid && !out_ready.
// Define CMP_COUNT_EN to add saturating GT/LT/EQ result counters with a synchronous clear.
module comparator_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    comparator_pipe_if.slave cmp
`ifdef CMP_COUNT_EN
    ,
    input  logic             cnt_clr,
    output logic [15:0]      cnt_gt,
    output logic [15:0]      cnt_lt,
    output logic [15:0]      cnt_eq
`endif
);
    localparam int CHUNK = WIDTH / STAGES;

    typedef enum logic [1:0] {
        DEC_UND = 2'd0,
        DEC_GT  = 2'd1,
        DEC_LT  = 2'd2
    } dec_e;

    logic [STAGES-1:0] vld_q, vld_d;
    dec_e              dec_q [STAGES];
    dec_e              dec_d [STAGES];
    // Operands are shifted left each stage so the chunk under test is always the top CHUNK bits.
    logic [WIDTH-1:0]  ra_q  [STAGES];
    logic [WIDTH-1:0]  rb_q  [STAGES];
    logic [WIDTH-1:0]  ra_d  [STAGES];
    logic [WIDTH-1:0]  rb_d  [STAGES];
    logic [WIDTH-1:0]  sa, sb;
    logic              gt_q, lt_q, eq_q;
    logic              adv;

    function automatic dec_e resolve(input dec_e d, input logic [CHUNK-1:0] ca,
                                     input logic [CHUNK-1:0] cb);
        if (d != DEC_UND) return d;
        if (ca > cb)      return DEC_GT;
        if (ca < cb)      return DEC_LT;
        return DEC_UND;
    endfunction

    assign adv          = !vld_q[STAGES-1] || cmp.out_ready;
    assign cmp.in_ready = adv;
    assign cmp.out_valid = vld_q[STAGES-1];
    assign cmp.a_gt_b   = gt_q;
    assign cmp.a_lt_b   = lt_q;
    assign cmp.a_eq_b   = eq_q;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        sa            = cmp.a;
        sb            = cmp.b;
        sa[WIDTH-1]   = cmp.a[WIDTH-1] ^ cmp.is_signed;
        sb[WIDTH-1]   = cmp.b[WIDTH-1] ^ cmp.is_signed;
        vld_d         = '0;
        vld_d[0]      = cmp.in_valid;
        dec_d[0]      = resolve(DEC_UND, sa[WIDTH-1 -: CHUNK], sb[WIDTH-1 -: CHUNK]);
        ra_d[0]       = sa << CHUNK;
        rb_d[0]       = sb << CHUNK;
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            dec_d[k] = resolve(dec_q[k-1], ra_q[k-1][WIDTH-1 -: CHUNK], rb_q[k-1][WIDTH-1 -: CHUNK]);
            ra_d[k]  = ra_q[k-1] << CHUNK;
            rb_d[k]  = rb_q[k-1] << CHUNK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
        end else if (adv) begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
                if (vld_d[k]) begin
                    dec_q[k] <= dec_d[k];
                    ra_q[k]  <= ra_d[k];
                    rb_q[k]  <= rb_d[k];
                end
            end
            // Flags only move with a valid result so they keep their last value across bubbles.
            if (vld_d[STAGES-1]) begin
                gt_q <= (dec_d[STAGES-1] == DEC_GT);
                lt_q <= (dec_d[STAGES-1] == DEC_LT);
                eq_q <= (dec_d[STAGES-1] == DEC_UND);
            end
        end
    end

`ifdef CMP_COUNT_EN
    logic [15:0] cnt_gt_q, cnt_lt_q, cnt_eq_q;
    logic        xfer;

    assign xfer   = vld_q[STAGES-1] && cmp.out_ready;
    assign cnt_gt = cnt_gt_q;
    assign cnt_lt = cnt_lt_q;
    assign cnt_eq = cnt_eq_q;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_gt_q <= 16'd0;
            cnt_lt_q <= 16'd0;
            cnt_eq_q <= 16'd0;
        end else if (xfer) begin
            if (gt_q && cnt_gt_q != 16'hFFFF) cnt_gt_q <= cnt_gt_q + 16'd1;
            if (lt_q && cnt_lt_q != 16'hFFFF) cnt_lt_q <= cnt_lt_q + 16'd1;
            if (eq_q && cnt_eq_q != 16'hFFFF) cnt_eq_q <= cnt_eq_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_comparator_pipe.sv
// Directed bench for comparator_pipe: 16-bit/4-stage main instance plus an 8-bit/8-stage instance.
module tb_comparator_pipe;
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        logic [2:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [24];

    always #5 clk = ~clk;

    comparator_pipe_if #(.WIDTH(16)) m ();
    comparator_pipe_if #(.WIDTH(8))  m8 ();

`ifdef CMP_COUNT_EN
    logic        cnt_clr;
    logic [15:0] cnt_gt, cnt_lt, cnt_eq;
    logic        cnt8_clr;
    logic [15:0] cnt8_gt, cnt8_lt, cnt8_eq;
`endif

    comparator_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .cmp    (m)
`ifdef CMP_COUNT_EN
        ,
        .cnt_clr(cnt_clr),
        .cnt_gt (cnt_gt),
        .cnt_lt (cnt_lt),
        .cnt_eq (cnt_eq)
`endif
    );

    comparator_pipe #(.WIDTH(8), .STAGES(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .cmp    (m8)
`ifdef CMP_COUNT_EN
        ,
        .cnt_clr(cnt8_clr),
        .cnt_gt (cnt8_gt),
        .cnt_lt (cnt8_lt),
        .cnt_eq (cnt8_eq)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pair into an empty pipe; result must show after the 4th edge and be gone after the 5th.
    task automatic lat_test(input string name, input int idx);
        m.a         = tbl[idx].a;
        m.b         = tbl[idx].b;
        m.is_signed = tbl[idx].sgn;
        m.in_valid  = 1'b1;
        m.out_ready = 1'b1;
        step();
        m.in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            chk({name, "_early"}, {31'd0, m.out_valid}, 32'd0);
            step();
        end
        chk({name, "_result"}, {m.out_valid, m.a_gt_b, m.a_lt_b, m.a_eq_b}, {1'b1, tbl[idx].exp});
        step();
        chk({name, "_drained"}, {31'd0, m.out_valid}, 32'd0);
    endtask

    task automatic run_stream(input int first, input int n, input int stall_len);
        int       q[$];
        int       pushed, popped, cyc, stall_left, idx;
        bit       stalling, acc, xfer;
        logic [2:0] fl;
        pushed = 0; popped = 0; cyc = 0; stall_left = stall_len; stalling = 0;
        while (popped < n && cyc < 100) begin
            m.in_valid = (pushed < n);
            if (pushed < n) begin
                m.a         = tbl[first+pushed].a;
                m.b         = tbl[first+pushed].b;
                m.is_signed = tbl[first+pushed].sgn;
            end
            if (stall_left > 0 && (stalling || m.out_valid)) begin
                stalling    = 1;
                m.out_ready = 1'b0;
            end else begin
                stalling    = 0;
                m.out_ready = 1'b1;
            end
            #1;
            if (!m.out_ready) begin
                chk("stall_in_ready", {31'd0, m.in_ready}, 32'd0);
                chk("stall_hold", {m.out_valid, m.a_gt_b, m.a_lt_b, m.a_eq_b},
                    (q.size() > 0) ? {1'b1, tbl[q[0]].exp} : 4'b1000);
                stall_left--;
            end
            acc  = m.in_valid && m.in_ready;
            xfer = m.out_valid && m.out_ready;
            fl   = {m.a_gt_b, m.a_lt_b, m.a_eq_b};
            @(posedge clk);
            #1;
            cyc++;
            if (xfer) begin
                if (q.size() > 0) begin
                    idx = q.pop_front();
                    chk("stream_flags", {29'd0, fl}, {29'd0, tbl[idx].exp});
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL stream_spurious: result %0h with nothing in flight", fl);
                end
                popped++;
            end
            if (acc) begin
                q.push_back(first + pushed);
                pushed++;
            end
        end
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
        chk("stream_count", popped, n);
        chk("stream_cycles", cyc, n + 4 + stall_len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{16'h1234, 16'h1235, 1'b0, LT};
        tbl[1]  = '{16'hABCD, 16'hABCD, 1'b0, EQ};
        tbl[2]  = '{16'hFFFF, 16'h0000, 1'b0, GT};
        tbl[3]  = '{16'h8000, 16'h7FFF, 1'b0, GT};
        tbl[4]  = '{16'h8000, 16'h7FFF, 1'b1, LT};
        tbl[5]  = '{16'hFFFF, 16'h0000, 1'b1, LT};
        tbl[6]  = '{16'h8000, 16'h8001, 1'b1, LT};
        tbl[7]  = '{16'h7FFF, 16'h8000, 1'b1, GT};
        tbl[8]  = '{16'h0001, 16'h0100, 1'b0, LT};
        tbl[9]  = '{16'hF0F0, 16'hF0EF, 1'b1, GT};
        tbl[10] = '{16'h12F4, 16'h12E4, 1'b0, GT};
        tbl[11] = '{16'h8000, 16'h8000, 1'b1, EQ};
        tbl[12] = '{16'h0002, 16'h0001, 1'b0, GT};
        tbl[13] = '{16'h0100, 16'h00FF, 1'b0, GT};
        tbl[14] = '{16'h7FFF, 16'h8000, 1'b1, GT};
        tbl[15] = '{16'h0000, 16'hFFFF, 1'b1, GT};
        tbl[16] = '{16'hFFFF, 16'hFFFE, 1'b0, GT};
        tbl[17] = '{16'h0000, 16'h0001, 1'b0, LT};
        tbl[18] = '{16'hFFFF, 16'h0000, 1'b1, LT};
        tbl[19] = '{16'h8000, 16'h7FFF, 1'b1, LT};
        tbl[20] = '{16'h5A5A, 16'h5A5A, 1'b0, EQ};
        tbl[21] = '{16'h8000, 16'h8000, 1'b1, EQ};
        tbl[22] = '{16'h0000, 16'h0000, 1'b0, EQ};
        tbl[23] = '{16'h0000, 16'h0000, 1'b0, EQ};

        rst          = 1'b1;
        m.in_valid   = 1'b0;
        m.a          = '0;
        m.b          = '0;
        m.is_signed  = 1'b0;
        m.out_ready  = 1'b1;
        m8.in_valid  = 1'b0;
        m8.a         = '0;
        m8.b         = '0;
        m8.is_signed = 1'b0;
        m8.out_ready = 1'b1;
`ifdef CMP_COUNT_EN
        cnt_clr  = 1'b0;
        cnt8_clr = 1'b0;
`endif
        step();
        step();
        chk("reset_state", {m.out_valid, m.a_gt_b, m.a_lt_b, m.a_eq_b}, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("idle", {m.in_ready, m.out_valid, m.a_gt_b, m.a_lt_b, m.a_eq_b}, 5'b10000);
            step();
        end

        lat_test("lat_unsigned", 3);
        lat_test("lat_signed", 4);

        run_stream(0, 3, 0);
        run_stream(0, 12, 0);
        run_stream(0, 12, 3);

        // Three pairs in flight, then a one-cycle reset.
        m.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m.a         = tbl[i].a;
            m.b         = tbl[i].b;
            m.is_signed = tbl[i].sgn;
            m.in_valid  = 1'b1;
            step();
        end
        m.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_flush_state", {m.out_valid, m.a_gt_b, m.a_lt_b, m.a_eq_b}, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            chk("rst_no_emerge", {31'd0, m.out_valid}, 32'd0);
            step();
        end
        lat_test("lat_after_rst", 9);

        // Eight single-bit stages: signed 0x80 (-128) < 0x01, unsigned 0x80 > 0x01.
        for (int s = 0; s < 2; s++) begin
            m8.a         = 8'h80;
            m8.b         = 8'h01;
            m8.is_signed = (s == 0);
            m8.in_valid  = 1'b1;
            step();
            m8.in_valid = 1'b0;
            for (int k = 1; k < 8; k++) begin
                chk("w8_early", {31'd0, m8.out_valid}, 32'd0);
                step();
            end
            chk("w8_result", {m8.out_valid, m8.a_gt_b, m8.a_lt_b, m8.a_eq_b},
                (s == 0) ? {1'b1, LT} : {1'b1, GT});
            step();
        end

`ifdef CMP_COUNT_EN
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clear_gt", {16'd0, cnt_gt}, 32'd0);
        run_stream(12, 10, 0);
        chk("cnt_gt", {16'd0, cnt_gt}, 32'd5);
        chk("cnt_lt", {16'd0, cnt_lt}, 32'd3);
        chk("cnt_eq", {16'd0, cnt_eq}, 32'd2);
        m.a         = tbl[12].a;
        m.b         = tbl[12].b;
        m.is_signed = tbl[12].sgn;
        m.in_valid  = 1'b1;
        step();
        m.in_valid = 1'b0;
        repeat (3) step();
        chk("clr_xfer_valid", {m.out_valid, m.a_gt_b}, 2'b11);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_xfer_gt", {16'd0, cnt_gt}, 32'd0);
        chk("clr_xfer_lt", {16'd0, cnt_lt}, 32'd0);
        chk("clr_xfer_eq", {16'd0, cnt_eq}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
